systolic_output_deskew: RTL and testbench
=========================================

# systolic_output_deskew

Downstream stage of the systolic array. It captures the per-column partial-sum outputs (`of_data`), which leave the array staggered by one cycle per column. It realigns them into full result rows and buffers them in a FIFO. Rows are handed to the writeback/output-feature path over a valid/ready handshake. The array cannot stall, so the block flags any row it is forced to drop.

## Interface
Parameters:
- `sys_cols`, from `Config`: array column count; width of a result row.
- `P_BITWIDTH`, from `Config`: partial-sum width, signed two's complement.
- `FIFO_DEPTH`, default 8: result rows buffered; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of FIFO, skew pipeline and `overflow`.
- `in_valid`  in  1  high in the cycle `of_data[0]` carries a valid result row.
- `of_data`  in  `[sys_cols-1:0][P_BITWIDTH-1:0]`  array column outputs; column j is valid j cycles after `in_valid`.
- `out_valid`  out  1  FIFO head holds a row.
- `out_ready`  in  1  consumer accepts the head row.
- `out_data`  out  `[sys_cols-1:0][P_BITWIDTH-1:0]`  aligned row at the FIFO head.
- `fifo_count`  out  `$clog2(FIFO_DEPTH)+1`  rows currently stored.
- `overflow`  out  1  sticky: a row was dropped because the FIFO was full.

## Operation
- Skew pipeline:
  - Column j passes through `sys_cols-1-j` registers. Column `sys_cols-1` is unregistered.
  - `in_valid` passes through a `sys_cols-1` deep valid shift register.
  - The aligned valid `av` and aligned row `ar` appear together.
- `in_valid` may be high every cycle. Up to `sys_cols` rows may be in flight. No gaps are required.
- Push: `av` high writes `ar` into the FIFO at the tail.
- Pop: `out_valid && out_ready` advances the head.
- FIFO: circular buffer with separate read and write pointers, each wrapping modulo `FIFO_DEPTH`. `fifo_count` is tracked explicitly.
- Full, no pop, `av` high: the row is dropped, `overflow` sets, the FIFO is unchanged.
- Full, with pop and push in the same cycle: both take effect and the count is unchanged. This is not an overflow.
- Empty, push: the row becomes visible the next cycle. There is no combinational bypass.
- `out_data` is driven from the head entry and is stable while `out_valid && !out_ready`.
- `clr`:
  - Has priority over push and pop.
  - Empties the FIFO, zeroes the valid shift register (in-flight rows are discarded) and clears `overflow`.
  - Data registers are not cleared.
- `overflow` is cleared only by `rst` or `clr`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `fifo_count`=0, `overflow`=0, pointers 0, valid shift register 0.
- `in_valid` in cycle t:
  - Row is pushed at the clock edge ending cycle t+`sys_cols`-1.
  - `out_valid` is high from cycle t+`sys_cols`, if the FIFO was empty.
  - Latency is `sys_cols` cycles.
- Throughput: one row per cycle in and out.
- `fifo_count` and `overflow` are registered and update in the cycle after the causing edge event.
- `rst` asserted mid-operation: all state returns to reset values immediately and in-flight rows are lost.

## Configuration
- `OUTPUT_RELU_EN` defined:
  - Each element of `ar` is clamped at the push: negative values (MSB=1) become 0, non-negative values pass unchanged.
  - The skew pipeline holds raw values.
- `OUTPUT_RELU_EN` undefined: rows are stored exactly as received.

## Test plan
All scenarios use `sys_cols`=4, `P_BITWIDTH`=32, `FIFO_DEPTH`=4.

- **Single row:**
  - Stimulus: `in_valid` at cycle 10; columns 0..3 carry 11, 22, 33, 44 at cycles 10..13; `out_ready`=1.
  - Required: `out_valid` high in cycle 14 only, `out_data`={44,33,22,11}, `fifo_count` returns to 0.
- **Back-to-back:**
  - Stimulus: 6 rows on consecutive cycles, row k has every column equal to 100+k; `out_ready`=1.
  - Required: 6 consecutive `out_valid` cycles, rows in order, no `overflow`.
- **Overflow:**
  - Stimulus: `out_ready`=0; 5 rows.
  - Required: `fifo_count`=4, `overflow`=1; after `out_ready`=1, rows 0..3 are delivered and row 4 is absent.
- **Full with simultaneous push and pop:**
  - Stimulus: FIFO full; push and pop in the same cycle.
  - Required: count stays 4, `overflow` stays 0, order preserved.
- **Clear and reset:**
  - Stimulus: `clr` pulsed while 2 rows are in flight and 2 are stored.
  - Required: next cycle `fifo_count`=0, `out_valid`=0, and no late push from the in-flight rows.
  - Stimulus: `rst` low mid-burst.
  - Required: outputs are at reset values asynchronously.
- **ReLU (`OUTPUT_RELU_EN`):**
  - Stimulus: row {-5, 7, -1, 0}.
  - Required: output {0, 7, 0, 0}. Without the macro, the output is {-5, 7, -1, 0}.

Source files
------------

// File: rtl/systolic_output_deskew.sv
`default_nettype none
// ============================================================================
// Module   : systolic_output_deskew
// Brief    : Realigns staggered systolic-array column outputs into full rows
//            and buffers them in a FIFO with a valid/ready output handshake.
//            Optional macro OUTPUT_RELU_EN clamps negative elements on push.
// Revision : 1.0  initial release
// ============================================================================
module systolic_output_deskew #(
  parameter int sys_cols   = 4,
  parameter int P_BITWIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 in_valid,
  input  logic [sys_cols-1:0][P_BITWIDTH-1:0]  of_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [sys_cols-1:0][P_BITWIDTH-1:0]  out_data,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                 overflow
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(FIFO_DEPTH);

  logic [sys_cols-1:0][P_BITWIDTH-1:0] w_ar;
  logic [sys_cols-1:0][P_BITWIDTH-1:0] w_wr_row;
  logic                                w_av;

  // Column j is delayed by sys_cols-1-j stages so every column lines up with the last one.
  generate
    for (genvar j = 0; j < sys_cols; j++) begin : g_col
      if (j == sys_cols - 1) begin : g_pass
        assign w_ar[j] = of_data[j];
      end else begin : g_dly
        localparam int c_d = sys_cols - 1 - j;
        logic [c_d-1:0][P_BITWIDTH-1:0] r_pipe;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_pipe <= '0;
          end else begin
            r_pipe[0] <= of_data[j];
            for (int k = 1; k < c_d; k++) r_pipe[k] <= r_pipe[k-1];
          end
        end
        assign w_ar[j] = r_pipe[c_d-1];
      end
    end
  endgenerate

  generate
    if (sys_cols > 1) begin : g_vsr
      logic [sys_cols-2:0] r_vsr;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vsr <= '0;
        end else if (clr) begin
          r_vsr <= '0;
        end else begin
          r_vsr[0] <= in_valid;
          for (int k = 1; k < sys_cols - 1; k++) r_vsr[k] <= r_vsr[k-1];
        end
      end
      assign w_av = r_vsr[sys_cols-2];
    end else begin : g_novsr
      assign w_av = in_valid;
    end
  endgenerate

`ifdef OUTPUT_RELU_EN
  generate
    for (genvar j = 0; j < sys_cols; j++) begin : g_relu
      assign w_wr_row[j] = w_ar[j][P_BITWIDTH-1] ? '0 : w_ar[j];
    end
  endgenerate
`else
  assign w_wr_row = w_ar;
`endif

  logic [sys_cols-1:0][P_BITWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]                     r_wr_ptr;
  logic [c_aw-1:0]                     r_rd_ptr;
  logic [c_cw-1:0]                     r_count;
  logic                                r_ovf;
  logic                                w_full;
  logic                                w_pop;
  logic                                w_push;
  logic                                w_drop;

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
  assign w_full = (r_count == c_full);
  assign w_pop  = (r_count != '0) && out_ready;
  assign w_push = w_av && (!w_full || w_pop);
  assign w_drop = w_av && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wr_row;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_cw'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_cw'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_systolic_output_deskew.sv
`default_nettype none
// Bench for systolic_output_deskew: row-level queue model plus directed scenarios
// with literal expectations.
module tb_systolic_output_deskew;

  localparam int C = 4;
  localparam int P = 32;
  localparam int D = 4;

  typedef logic [C-1:0][P-1:0] row_t;
  typedef struct {
    int   start;
    row_t d;
    bit   dead;
  } pend_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  row_t       of_data = '0;
  logic       out_valid;
  row_t       out_data;
  logic [2:0] fifo_count;
  logic       overflow;

  always #5 clk = ~clk;

  systolic_output_deskew #(
    .sys_cols   (C),
    .P_BITWIDTH (P),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .of_data    (of_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  pend_t pend[$];
  row_t  mq[$];
  bit    m_ovf = 1'b0;
  row_t  got[$];

  task automatic chk(input string name, input logic [C*P-1:0] act, input logic [C*P-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic row_t mk(input int a, input int b, input int c, input int d);
    row_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic row_t relu(input row_t r);
    row_t o;
    o = r;
`ifdef OUTPUT_RELU_EN
    for (int j = 0; j < C; j++) if (o[j][P-1]) o[j] = '0;
`endif
    return o;
  endfunction

  task automatic add_row(input int start, input row_t d);
    pend_t p;
    p.start = start; p.d = d; p.dead = 1'b0;
    pend.push_back(p);
  endtask

  // Column j of a row that entered at cycle s is presented at cycle s+j.
  task automatic drive();
    in_valid = 1'b0;
    for (int j = 0; j < C; j++) of_data[j] = $urandom;
    foreach (pend[i]) begin
      if (!pend[i].dead) begin
        for (int j = 0; j < C; j++)
          if (pend[i].start == cyc - j) of_data[j] = pend[i].d[j];
        if (pend[i].start == cyc) in_valid = 1'b1;
      end
    end
  endtask

  // Row-level effect of the clock edge that ends cycle cyc.
  task automatic model();
    bit   arr;
    bit   pop;
    bit   full;
    row_t a;
    arr = 1'b0;
    a   = '0;
    if (clr) begin
      foreach (pend[i])
        if (pend[i].start >= cyc - (C - 1) && pend[i].start <= cyc) pend[i].dead = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      foreach (pend[i])
        if (!pend[i].dead && pend[i].start == cyc - (C - 1)) begin
          arr = 1'b1;
          a   = pend[i].d;
        end
      pop  = (mq.size() > 0) && out_ready;
      full = (mq.size() == D);
      if (pop) void'(mq.pop_front());
      if (arr) begin
        if (!full || pop) mq.push_back(relu(a));
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk);
      model();
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("model_valid", out_valid, (mq.size() != 0));
      chk("model_count", fifo_count, mq.size());
      chk("model_ovf", overflow, m_ovf);
      if (mq.size() != 0) chk("model_data", out_data, mq[0]);
    end
  end

  initial begin
    row_t e;

    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    #1 rst = 1'b1;
    cyc = 0;

    // Single row entering at cycle 10
    run(10);
    add_row(10, mk(11, 22, 33, 44));
    run(3);
    chk("s1_valid_c13", out_valid, 0);
    run(1);
    chk("s1_valid_c14", out_valid, 1);
    chk("s1_data", out_data, {32'd44, 32'd33, 32'd22, 32'd11});
    run(1);
    chk("s1_valid_c15", out_valid, 0);
    chk("s1_count", fifo_count, 0);

    // Back-to-back rows
    got.delete();
    for (int k = 0; k < 6; k++) add_row(cyc + k, mk(100 + k, 100 + k, 100 + k, 100 + k));
    run(12);
    chk("s2_rows", got.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < got.size()) chk("s2_row", got[k], mk(100 + k, 100 + k, 100 + k, 100 + k));
    chk("s2_ovf", overflow, 0);

    // Overflow with the consumer stalled
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) add_row(cyc + k, mk(200 + k, 200 + k, 200 + k, 200 + k));
    run(10);
    chk("s3_count", fifo_count, 4);
    chk("s3_ovf", overflow, 1);
    got.delete();
    out_ready = 1'b1;
    run(6);
    chk("s3_rows", got.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) chk("s3_row", got[k], mk(200 + k, 200 + k, 200 + k, 200 + k));
    chk("s3_ovf_sticky", overflow, 1);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    chk("s3_clr_ovf", overflow, 0);
    chk("s3_clr_count", fifo_count, 0);

    // Full FIFO with push and pop on the same edge
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) add_row(cyc + k, mk(300 + k, 300 + k, 300 + k, 300 + k));
    run(8);
    chk("s4_full", fifo_count, 4);
    add_row(cyc, mk(304, 304, 304, 304));
    run(3);
    got.delete();
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    chk("s4_count", fifo_count, 4);
    chk("s4_ovf", overflow, 0);
    chk("s4_pop_n", got.size(), 1);
    if (got.size() > 0) chk("s4_pop_row", got[0], mk(300, 300, 300, 300));
    got.delete();
    out_ready = 1'b1;
    run(6);
    chk("s4_rows", got.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) chk("s4_row", got[k], mk(301 + k, 301 + k, 301 + k, 301 + k));

    // Clear with two rows stored and two in flight
    out_ready = 1'b0;
    add_row(cyc, mk(400, 400, 400, 400));
    add_row(cyc + 1, mk(401, 401, 401, 401));
    run(5);
    chk("s5_stored", fifo_count, 2);
    add_row(cyc, mk(402, 402, 402, 402));
    add_row(cyc + 1, mk(403, 403, 403, 403));
    run(2);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    chk("s5_clr_count", fifo_count, 0);
    chk("s5_clr_valid", out_valid, 0);
    run(6);
    chk("s5_no_late_count", fifo_count, 0);
    chk("s5_no_late_valid", out_valid, 0);

    // Asynchronous reset in the middle of a burst
    for (int k = 0; k < 6; k++) add_row(cyc + k, mk(500 + k, 500 + k, 500 + k, 500 + k));
    run(6);
    chk("s6_stored", fifo_count, 3);
    #1 rst = 1'b0;
    #1;
    chk("s6_rst_valid", out_valid, 0);
    chk("s6_rst_data", out_data, 0);
    chk("s6_rst_count", fifo_count, 0);
    chk("s6_rst_ovf", overflow, 0);
    mq.delete();
    m_ovf = 1'b0;
    foreach (pend[i]) pend[i].dead = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    cyc++;
    out_ready = 1'b1;
    run(8);
    chk("s6_after_count", fifo_count, 0);
    chk("s6_after_valid", out_valid, 0);

    // Signed row through the optional clamp
    add_row(cyc, mk(-5, 7, -1, 0));
    run(4);
    chk("s7_valid", out_valid, 1);
`ifdef OUTPUT_RELU_EN
    e = mk(0, 7, 0, 0);
`else
    e = mk(-5, 7, -1, 0);
`endif
    chk("s7_data", out_data, e);
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
